// File: rtl/reg_file_pkg.sv
// ============================================================================
// reg_file_pkg : shared widths and constants for the CPU register file
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

package reg_file_pkg;

  localparam int REG_COUNT  = 32;
  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;

  localparam logic [ADDR_WIDTH-1:0] ZERO_REG = 5'd0;

  typedef logic [DATA_WIDTH-1:0] word_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;

endpackage

`default_nettype wire

// File: rtl/reg_file_register32.sv
// ============================================================================
// reg_file_register32 : 32-bit register with synchronous reset and write enable
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module reg_file_register32
  import reg_file_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  we_i,
  input  word_t d_i,
  output word_t q_o
);

  word_t data_d;
  word_t data_q;

  always_comb begin
    data_d = data_q;
    if (we_i) begin
      data_d = d_i;
    end
  end

  // Reset wins over a simultaneous write
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q_o = data_q;

endmodule

`default_nettype wire

// File: rtl/reg_file.sv
// ============================================================================
// reg_file : 32x32 register file, two combinational read ports, one write port
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module reg_file
  import reg_file_pkg::*;
(
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [ADDR_WIDTH-1:0] ReadRegister1,
  input  logic [ADDR_WIDTH-1:0] ReadRegister2,
  output logic [DATA_WIDTH-1:0] ReadData1,
  output logic [DATA_WIDTH-1:0] ReadData2,
  input  logic [ADDR_WIDTH-1:0] WriteRegister,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic                  RegWrite
);

  word_t w_regs [REG_COUNT];
  logic  [REG_COUNT-1:1] w_we;

  // One-hot write decoder; address 0 has no enable line, so its writes vanish
  always_comb begin
    w_we = '0;
    for (int i = 1; i < REG_COUNT; i++) begin
      if (RegWrite && (WriteRegister == ADDR_WIDTH'(i))) begin
        w_we[i] = 1'b1;
      end
    end
  end

  assign w_regs[ZERO_REG] = '0;

  for (genvar i = 1; i < REG_COUNT; i++) begin : g_regs
    reg_file_register32 u_reg (
      .clk_i (Clk),
      .rst_i (Reset),
      .we_i  (w_we[i]),
      .d_i   (WriteData),
      .q_o   (w_regs[i])
    );
  end

  assign ReadData1 = w_regs[ReadRegister1];
  assign ReadData2 = w_regs[ReadRegister2];

endmodule

`default_nettype wire

// File: tb/tb_reg_file.sv
// ============================================================================
// tb_reg_file : randomized bench for reg_file against an array model
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_reg_file;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [4:0]  ReadRegister1, ReadRegister2, WriteRegister;
  logic [31:0] ReadData1, ReadData2, WriteData;
  logic        RegWrite;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] model [32];
  bit          model_valid = 1'b0;

  reg_file dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .ReadRegister1 (ReadRegister1),
    .ReadRegister2 (ReadRegister2),
    .ReadData1     (ReadData1),
    .ReadData2     (ReadData2),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .RegWrite      (RegWrite)
  );

  always #5 Clk = ~Clk;

  // Reference: an array updated at each rising edge from the sampled inputs
  always @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
      model_valid = 1'b1;
    end else if (RegWrite && WriteRegister != 5'd0) begin
      model[WriteRegister] = WriteData;
    end
  end

  function automatic logic [31:0] model_rd(input logic [4:0] a);
    return (a == 5'd0) ? 32'h0 : model[a];
  endfunction

  always @(negedge Clk) begin
    if (model_valid) begin
      n_checks++;
      if (ReadData1 !== model_rd(ReadRegister1)) begin
        n_fail++;
        $display("FAIL port1 addr=%0d got=%h exp=%h", ReadRegister1, ReadData1, model_rd(ReadRegister1));
      end
      n_checks++;
      if (ReadData2 !== model_rd(ReadRegister2)) begin
        n_fail++;
        $display("FAIL port2 addr=%0d got=%h exp=%h", ReadRegister2, ReadData2, model_rd(ReadRegister2));
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic cyc(input bit rst, input bit we, input logic [4:0] wa, input logic [31:0] wd);
    Reset = rst; RegWrite = we; WriteRegister = wa; WriteData = wd;
    @(posedge Clk);
    #2;
    Reset = 1'b0; RegWrite = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a1, input logic [4:0] a2);
    ReadRegister1 = a1; ReadRegister2 = a2;
    #1;
  endtask

  initial begin
    Reset = 1'b1; RegWrite = 1'b0; WriteRegister = '0; WriteData = '0;
    ReadRegister1 = '0; ReadRegister2 = '0;
    @(posedge Clk);
    #2;
    Reset = 1'b0;

    for (int a = 0; a < 32; a++) begin
      rd(a[4:0], 5'(31 - a));
      chk("reset_p1", ReadData1, 32'h0);
      chk("reset_p2", ReadData2, 32'h0);
    end

    cyc(0, 1, 5'd2, 32'd42);
    rd(5'd2, 5'd2);
    chk("wr42_p1", ReadData1, 32'd42);
    chk("wr42_p2", ReadData2, 32'd42);

    for (int a = 0; a < 32; a++) begin
      rd(5'd2, a[4:0]);
      chk("decoder_iso", ReadData2, (a == 2) ? 32'd42 : 32'h0);
    end

    cyc(0, 1, 5'd2, 32'd15);
    cyc(0, 0, 5'd2, 32'd42);
    rd(5'd0, 5'd2);
    chk("no_we_hold", ReadData2, 32'd15);

    cyc(0, 1, 5'd4, 32'd42);
    rd(5'd2, 5'd4);
    chk("two_port_r2", ReadData1, 32'd15);
    chk("two_port_r4", ReadData2, 32'd42);

    cyc(0, 1, 5'd0, 32'd15);
    rd(5'd0, 5'd0);
    chk("r0_discard", ReadData1, 32'h0);

    // A read during the write cycle must still see the old value
    rd(5'd7, 5'd7);
    Reset = 1'b0; RegWrite = 1'b1; WriteRegister = 5'd7; WriteData = 32'h1234;
    #1;
    chk("no_bypass", ReadData1, 32'h0);
    @(posedge Clk);
    #2;
    RegWrite = 1'b0;
    chk("after_edge", ReadData1, 32'h1234);

    cyc(0, 1, 5'd31, 32'hDEADBEEF);
    rd(5'd31, 5'd5);
    chk("r31_written", ReadData1, 32'hDEADBEEF);
    cyc(1, 1, 5'd5, 32'd7);
    rd(5'd31, 5'd5);
    chk("rst_prio_r31", ReadData1, 32'h0);
    chk("rst_prio_r5", ReadData2, 32'h0);

    for (int n = 0; n < 3000; n++) begin
      rd(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      cyc(($urandom_range(0, 99) == 0), $urandom_range(0, 1) == 1,
          5'($urandom_range(0, 31)), $urandom);
    end

    @(negedge Clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
